// File: rtl/div_unit.sv
// Iterative 32-bit divider for the EX stage: one restoring shift-subtract step per
// cycle, signed (DIV) and unsigned (DIVU), with divide-by-zero and flush handling.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divStateT;

  divStateT    state;
  divStateT    nextState;

  logic [5:0]  stepCount;
  logic [63:0] workReg;
  logic [31:0] divisorMag;
  logic        quoNeg;
  logic        remNeg;

  logic [31:0] aMag;
  logic [31:0] bMag;
  logic        accept;
  logic        lastStep;
  logic [32:0] remShift;
  logic [32:0] trial;
  logic        canSub;
  logic [63:0] stepReg;
  logic [31:0] finalQuo;
  logic [31:0] finalRem;

  // Handshake: start is held by the pipeline while stall=1; the operation is taken
  // in the IDLE cycle where start=1 and cancel=0, and stall drops in the DONE cycle.
  assign aMag     = (signed_div && a[31]) ? (~a + 32'd1) : a;
  assign bMag     = (signed_div && b[31]) ? (~b + 32'd1) : b;
  assign accept   = (state == IDLE) && start && !cancel;
  assign lastStep = (state == BUSY) && (stepCount == 6'd31);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall = 1'b1;
          nextState = (b == 32'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (stepCount == 6'd31) begin
          nextState = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
    if (cancel) begin
      nextState = IDLE;
      stall     = 1'b0;
    end
    if (!resetn) begin
      stall = 1'b0;
    end
  end

  // The shifted partial remainder needs 33 bits: with a divisor above 2^31 it can
  // exceed 32 bits before the subtract brings it back below the divisor.
  always_comb begin
    remShift = workReg[63:31];
    trial    = remShift - {1'b0, divisorMag};
    canSub   = !trial[32];
    if (canSub) begin
      stepReg = {trial[31:0], workReg[30:0], 1'b1};
    end else begin
      stepReg = {workReg[62:0], 1'b0};
    end
    finalQuo = quoNeg ? (~stepReg[31:0] + 32'd1) : stepReg[31:0];
    finalRem = remNeg ? (~stepReg[63:32] + 32'd1) : stepReg[63:32];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stepCount    <= 6'd0;
      workReg      <= 64'd0;
      divisorMag   <= 32'd0;
      quoNeg       <= 1'b0;
      remNeg       <= 1'b0;
      result_valid <= 1'b0;
      quotient     <= 32'd0;
      remainder    <= 32'd0;
    end else begin
      result_valid <= 1'b0;
      if (accept) begin
        workReg    <= {32'd0, aMag};
        divisorMag <= bMag;
        quoNeg     <= (a[31] ^ b[31]) & signed_div;
        remNeg     <= a[31] & signed_div;
        stepCount  <= 6'd0;
        if (b == 32'd0) begin
          quotient     <= 32'hFFFF_FFFF;
          remainder    <= a;
          result_valid <= 1'b1;
        end
      end else if ((state == BUSY) && !cancel) begin
        workReg   <= stepReg;
        stepCount <= stepCount + 6'd1;
        if (lastStep) begin
          quotient     <= finalQuo;
          remainder    <= finalRem;
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed literal cases plus randomized operations, all compared
// every cycle against a latency/arithmetic model built from plain integer division.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        stall;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .signed_div   (signed_div),
    .a            (a),
    .b            (b),
    .cancel       (cancel),
    .stall        (stall),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: 64-bit integer division truncates toward zero and the
  // remainder takes the dividend's sign; the low 32 bits give the wrapped result.
  function automatic logic [31:0] modelQ(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    longint sa, sb, t;
    if (tb == 32'd0) return 32'hFFFF_FFFF;
    sa = ts ? longint'({{32{ta[31]}}, ta}) : longint'({32'd0, ta});
    sb = ts ? longint'({{32{tb[31]}}, tb}) : longint'({32'd0, tb});
    t  = sa / sb;
    return t[31:0];
  endfunction

  function automatic logic [31:0] modelR(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    longint sa, sb, t;
    if (tb == 32'd0) return ta;
    sa = ts ? longint'({{32{ta[31]}}, ta}) : longint'({32'd0, ta});
    sb = ts ? longint'({{32{tb[31]}}, tb}) : longint'({32'd0, tb});
    t  = sa % sb;
    return t[31:0];
  endfunction

  // model: an accepted op occupies 32 further stall cycles, then one result cycle
  logic        mBusy;
  logic        mDone;
  int          mLeft;
  logic [31:0] mPendQ;
  logic [31:0] mPendR;
  logic        expValid;
  logic [31:0] expQ;
  logic [31:0] expR;
  logic        expStall;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mBusy    <= 1'b0;
      mDone    <= 1'b0;
      mLeft    <= 0;
      mPendQ   <= 32'd0;
      mPendR   <= 32'd0;
      expValid <= 1'b0;
      expQ     <= 32'd0;
      expR     <= 32'd0;
    end else begin
      expValid <= 1'b0;
      if (cancel) begin
        mBusy <= 1'b0;
        mDone <= 1'b0;
      end else if (mDone) begin
        mDone <= 1'b0;
      end else if (mBusy) begin
        if (mLeft == 1) begin
          mBusy    <= 1'b0;
          mDone    <= 1'b1;
          expValid <= 1'b1;
          expQ     <= mPendQ;
          expR     <= mPendR;
        end else begin
          mLeft <= mLeft - 1;
        end
      end else if (start) begin
        if (b == 32'd0) begin
          mDone    <= 1'b1;
          expValid <= 1'b1;
          expQ     <= modelQ(a, b, signed_div);
          expR     <= modelR(a, b, signed_div);
        end else begin
          mBusy  <= 1'b1;
          mLeft  <= 32;
          mPendQ <= modelQ(a, b, signed_div);
          mPendR <= modelR(a, b, signed_div);
        end
      end
    end
  end

  assign expStall = resetn && !cancel && (mBusy || (!mDone && start));

  // scoreboard compare, mid-cycle
  always @(negedge clk) begin
    check("cyc_stall", {31'd0, stall}, {31'd0, expStall});
    check("cyc_valid", {31'd0, result_valid}, {31'd0, expValid});
    check("cyc_quotient", quotient, expQ);
    check("cyc_remainder", remainder, expR);
  end

  // driver tasks
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                       input logic [31:0] eq, input logic [31:0] er, input int es,
                       input string tag);
    int  n;
    bit  fin;
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb; signed_div = ts; cancel = 1'b0;
    n = 0; fin = 0;
    for (int i = 0; i < 80 && !fin; i++) begin
      @(negedge clk);
      if (stall) n++;
      else fin = 1;
    end
    if (!fin) begin
      check({tag, "_timeout"}, 32'd1, 32'd0);
    end else begin
      check({tag, "_stall_cycles"}, n, es);
      check({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
      check({tag, "_q"}, quotient, eq);
      check({tag, "_r"}, remainder, er);
    end
  endtask

  task automatic rand_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                         input int cancelAt);
    int k;
    bit fin;
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb; signed_div = ts; cancel = (cancelAt == 0);
    k = 0; fin = 0;
    for (int i = 0; i < 80 && !fin; i++) begin
      @(negedge clk);
      if (!stall) begin
        fin = 1;
      end else begin
        k++;
        @(posedge clk); #1;
        if (k == cancelAt) cancel = 1'b1;
      end
    end
    if (!fin) check("rand_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          sel, cAt;

    resetn = 1'b0; start = 1'b1; signed_div = 1'b0;
    a = 32'd5; b = 32'd1; cancel = 1'b0;
    #2;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_valid", {31'd0, result_valid}, 32'd0);
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;
    idle(2);

    do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, "udiv");
    idle(1);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "sdiv");
    idle(1);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, "sovf");
    idle(1);
    do_op(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1, "div0");
    idle(2);

    // flush mid-operation
    @(posedge clk); #1;
    start = 1'b1; a = 32'd6; b = 32'd3; signed_div = 1'b0;
    repeat (11) @(posedge clk);
    #1; cancel = 1'b1; start = 1'b0;
    @(negedge clk);
    check("cancel_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1; cancel = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("cancel_valid", {31'd0, result_valid}, 32'd0);
      check("cancel_q", quotient, 32'hFFFF_FFFF);
      check("cancel_r", remainder, 32'h0000_1234);
    end

    // back-to-back: start stays high through DONE
    do_op(32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 33, "b2b_first");
    do_op(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 33, "b2b_second");
    idle(2);

    // reset in the middle of BUSY, start left high during reset
    @(posedge clk); #1;
    start = 1'b1; a = 32'd1000; b = 32'd7; signed_div = 1'b0;
    repeat (6) @(posedge clk);
    #1; resetn = 1'b0;
    #1;
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    check("midrst_valid", {31'd0, result_valid}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;
    idle(1);
    do_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 33, "after_rst");
    idle(1);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        3:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      rs  = 1'($urandom_range(0, 1));
      cAt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 34) : -1;
      rand_op(ra, rb, rs, cAt);
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
